bp_io_dev_router: RTL and testbench

- Single-outstanding I/O request router between a core's uncached I/O port and the five tile-local devices: boot, host, cfg, clint, cache.
- Decodes the device field of each request address and forwards the request to exactly one device.
- Waits for that device's response, with a timeout, and returns the response to the requester.
- Unmapped addresses and timeouts produce an error response; the core never hangs.

---
 rtl/bp_common_pkg.sv | 24 ++
 rtl/bp_io_dev_router_if.sv | 27 ++
 rtl/bp_io_dev_decode.sv | 30 +++
 rtl/bp_io_dev_router.sv | 197 +++++++++++++++++++
 tb/tb_bp_io_dev_router.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_common_pkg.sv
// Common BlackParrot constants and types shared by the tile-local I/O path.
package bp_common_pkg;

  // Device-field layout of a tile-local I/O physical address
  localparam int unsigned bp_dev_id_width_gp     = 4;
  localparam int unsigned bp_dev_offset_width_gp = 20;

  // Tile-local device indices (also the dev_id field value)
  localparam int unsigned boot_dev_gp  = 0;
  localparam int unsigned host_dev_gp  = 1;
  localparam int unsigned cfg_dev_gp   = 2;
  localparam int unsigned clint_dev_gp = 3;
  localparam int unsigned cache_dev_gp = 4;

  // Tile-local device base addresses (addr[23:0])
  localparam logic [23:0] boot_dev_base_addr_gp  = 24'h00_0000;
  localparam logic [23:0] host_dev_base_addr_gp  = 24'h10_0000;
  localparam logic [23:0] cfg_dev_base_addr_gp   = 24'h20_0000;
  localparam logic [23:0] clint_dev_base_addr_gp = 24'h30_0000;
  localparam logic [23:0] cache_dev_base_addr_gp = 24'h40_0000;

  typedef enum logic [1:0] {e_idle, e_send, e_wait, e_resp} bp_io_router_state_e;

endpackage

// File: rtl/bp_io_dev_router_if.sv
// Requester-side uncached I/O request/response bus of the device router.
interface bp_io_dev_router_if #(
  parameter int unsigned paddr_width_p = 40,
  parameter int unsigned data_width_p  = 64
);
  logic                     req_v_i;
  logic                     req_ready_o;
  logic [paddr_width_p-1:0] req_addr_i;
  logic                     req_we_i;
  logic [data_width_p-1:0]  req_data_i;
  logic                     resp_v_o;
  logic                     resp_yumi_i;
  logic [data_width_p-1:0]  resp_data_o;
  logic                     resp_err_o;

  // Router side
  modport slave (
    input  req_v_i, req_addr_i, req_we_i, req_data_i, resp_yumi_i,
    output req_ready_o, resp_v_o, resp_data_o, resp_err_o
  );

  // Core side
  modport master (
    output req_v_i, req_addr_i, req_we_i, req_data_i, resp_yumi_i,
    input  req_ready_o, resp_v_o, resp_data_o, resp_err_o
  );
endinterface

// File: rtl/bp_io_dev_decode.sv
// Combinational tile-local device decode: dev_id = addr[23:20], mapped and one-hot select.
module bp_io_dev_decode
  import bp_common_pkg::*;
#(
  parameter int unsigned paddr_width_p = 40,
  parameter int unsigned num_dev_p     = cache_dev_gp + 1
) (
  input  logic [paddr_width_p-1:0]      addr_i,
  output logic [bp_dev_id_width_gp-1:0] dev_id_c,
  output logic                          mapped_c,
  output logic [num_dev_p-1:0]          sel_c
);

  // Tile bits above the device field and the device offset are not part of routing
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[paddr_width_p-1:bp_dev_offset_width_gp+bp_dev_id_width_gp],
                              addr_i[bp_dev_offset_width_gp-1:0]};

  assign dev_id_c = addr_i[bp_dev_offset_width_gp +: bp_dev_id_width_gp];
  assign mapped_c = (32'(dev_id_c) < num_dev_p);

  // One-hot device select, all zero when unmapped
  always_comb begin
    sel_c = '0;
    for (int unsigned i = 0; i < num_dev_p; i++) begin
      sel_c[i] = mapped_c && (dev_id_c == bp_dev_id_width_gp'(i));
    end
  end

endmodule

// File: rtl/bp_io_dev_router.sv
// Single-outstanding uncached I/O router from a core to the five tile-local devices.
// Optional: define BP_IO_ROUTER_ERR_COUNT_EN for a saturating error-response counter.
module bp_io_dev_router
  import bp_common_pkg::*;
#(
  parameter int unsigned paddr_width_p    = 40,
  parameter int unsigned data_width_p     = 64,
  parameter int unsigned num_dev_p        = cache_dev_gp + 1,
  parameter int unsigned timeout_cycles_p = 1024
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  bp_io_dev_router_if.slave                     io,
  output logic [num_dev_p-1:0]                  dev_v_o,
  input  logic [num_dev_p-1:0]                  dev_ready_i,
  output logic [bp_dev_offset_width_gp-1:0]     dev_addr_o,
  output logic                                  dev_we_o,
  output logic [data_width_p-1:0]               dev_data_o,
  input  logic [num_dev_p-1:0]                  dev_resp_v_i,
  input  logic [num_dev_p*data_width_p-1:0]     dev_resp_data_i,
  output logic [num_dev_p-1:0]                  dev_resp_ready_o,
  output logic [15:0]                           err_count_o
);

  localparam int unsigned cnt_width_lp = $clog2(timeout_cycles_p);
  localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(timeout_cycles_p - 1);

  bp_io_router_state_e state_q, state_d;

  logic                              req_ready_q, req_ready_d;
  logic                              resp_v_q, resp_v_d;
  logic                              resp_err_q, resp_err_d;
  logic [data_width_p-1:0]           resp_data_q, resp_data_d;
  logic [num_dev_p-1:0]              dev_v_q, dev_v_d;
  logic [num_dev_p-1:0]              sel_q, sel_d;
  logic [bp_dev_id_width_gp-1:0]     dev_id_q, dev_id_d;
  logic [bp_dev_offset_width_gp-1:0] addr_q, addr_d;
  logic                              we_q, we_d;
  logic [data_width_p-1:0]           data_q, data_d;
  logic [cnt_width_lp-1:0]           cnt_q, cnt_d;

  logic [bp_dev_id_width_gp-1:0]     dec_dev_id;
  logic                              dec_mapped;
  logic [num_dev_p-1:0]              dec_sel;
  logic [data_width_p-1:0]           resp_slice;

  bp_io_dev_decode #(
    .paddr_width_p (paddr_width_p),
    .num_dev_p     (num_dev_p)
  ) u_decode (
    .addr_i   (io.req_addr_i),
    .dev_id_c (dec_dev_id),
    .mapped_c (dec_mapped),
    .sel_c    (dec_sel)
  );

  // Select the response data slice of the device currently being served
  always_comb begin
    resp_slice = '0;
    for (int unsigned i = 0; i < num_dev_p; i++) begin
      if (dev_id_q == bp_dev_id_width_gp'(i)) begin
        resp_slice = dev_resp_data_i[i*data_width_p +: data_width_p];
      end
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    dev_id_d    = dev_id_q;
    addr_d      = addr_q;
    we_d        = we_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    resp_err_d  = resp_err_q;
    resp_data_d = resp_data_q;

    case (state_q)
      e_idle: begin
        if (io.req_v_i && req_ready_q) begin
          sel_d    = dec_sel;
          dev_id_d = dec_dev_id;
          addr_d   = io.req_addr_i[bp_dev_offset_width_gp-1:0];
          we_d     = io.req_we_i;
          data_d   = io.req_data_i;
          if (dec_mapped) begin
            state_d = e_send;
          end else begin
            state_d     = e_resp;
            resp_err_d  = 1'b1;
            resp_data_d = '0;
          end
        end
      end
      e_send: begin
        if (|(dev_ready_i & sel_q)) begin
          state_d = e_wait;
          cnt_d   = '0;
        end
      end
      e_wait: begin
        // A response on the expiry cycle takes priority over the timeout
        if (|(dev_resp_v_i & sel_q)) begin
          state_d     = e_resp;
          resp_err_d  = 1'b0;
          resp_data_d = resp_slice;
        end else if (cnt_q == cnt_max_lp) begin
          state_d     = e_resp;
          resp_err_d  = 1'b1;
          resp_data_d = '0;
        end else begin
          cnt_d = cnt_q + cnt_width_lp'(1);
        end
      end
      e_resp: begin
        if (io.resp_yumi_i) begin
          state_d = e_idle;
        end
      end
      default: state_d = e_idle;
    endcase

    req_ready_d = (state_d == e_idle);
    resp_v_d    = (state_d == e_resp);
    dev_v_d     = (state_d == e_send) ? sel_d : '0;
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= e_idle;
      req_ready_q <= 1'b0;
      resp_v_q    <= 1'b0;
      resp_err_q  <= 1'b0;
      resp_data_q <= '0;
      dev_v_q     <= '0;
      sel_q       <= '0;
      dev_id_q    <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      data_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      resp_v_q    <= resp_v_d;
      resp_err_q  <= resp_err_d;
      resp_data_q <= resp_data_d;
      dev_v_q     <= dev_v_d;
      sel_q       <= sel_d;
      dev_id_q    <= dev_id_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef BP_IO_ROUTER_ERR_COUNT_EN
  logic [15:0] err_count_q, err_count_d;

  // Count entries into an error response, saturating at all-ones
  always_comb begin
    err_count_d = err_count_q;
    if ((state_q != e_resp) && (state_d == e_resp) && resp_err_d && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  // Error counter register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count_o = err_count_q;
`else
  assign err_count_o = '0;
`endif

  // Non-selected devices and stray late responses are always drained
  assign dev_resp_ready_o = {num_dev_p{1'b1}};

  assign io.req_ready_o = req_ready_q;
  assign io.resp_v_o    = resp_v_q;
  assign io.resp_err_o  = resp_err_q;
  assign io.resp_data_o = resp_data_q;
  assign dev_v_o        = dev_v_q;
  assign dev_addr_o     = addr_q;
  assign dev_we_o       = we_q;
  assign dev_data_o     = data_q;

endmodule

// File: tb/tb_bp_io_dev_router.sv
// Directed self-checking bench for bp_io_dev_router (timeout_cycles_p = 16).
module tb_bp_io_dev_router;

  localparam int unsigned aw_lp  = 40;
  localparam int unsigned dw_lp  = 64;
  localparam int unsigned nd_lp  = 5;
  localparam int unsigned to_lp  = 16;
`ifdef BP_IO_ROUTER_ERR_COUNT_EN
  localparam logic [15:0] ec1_lp = 16'd1;
  localparam logic [15:0] ec2_lp = 16'd2;
`else
  localparam logic [15:0] ec1_lp = 16'd0;
  localparam logic [15:0] ec2_lp = 16'd0;
`endif

  logic                   clk_i;
  logic                   reset_n_i;
  logic [nd_lp-1:0]       dev_v_o;
  logic [nd_lp-1:0]       dev_ready_i;
  logic [19:0]            dev_addr_o;
  logic                   dev_we_o;
  logic [dw_lp-1:0]       dev_data_o;
  logic [nd_lp-1:0]       dev_resp_v_i;
  logic [nd_lp*dw_lp-1:0] dev_resp_data_i;
  logic [nd_lp-1:0]       dev_resp_ready_o;
  logic [15:0]            err_count_o;

  int checks;
  int errors;

  bp_io_dev_router_if #(.paddr_width_p(aw_lp), .data_width_p(dw_lp)) io ();

  bp_io_dev_router #(
    .paddr_width_p    (aw_lp),
    .data_width_p     (dw_lp),
    .num_dev_p        (nd_lp),
    .timeout_cycles_p (to_lp)
  ) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .io               (io),
    .dev_v_o          (dev_v_o),
    .dev_ready_i      (dev_ready_i),
    .dev_addr_o       (dev_addr_o),
    .dev_we_o         (dev_we_o),
    .dev_data_o       (dev_data_o),
    .dev_resp_v_i     (dev_resp_v_i),
    .dev_resp_data_i  (dev_resp_data_i),
    .dev_resp_ready_o (dev_resp_ready_o),
    .err_count_o      (err_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one request while idle; returns one cycle after the accepting edge
  task automatic issue(input logic [39:0] a, input logic we, input logic [63:0] d);
    chk("idle_ready", 64'(io.req_ready_o), 64'd1);
    io.req_v_i    = 1'b1;
    io.req_addr_i = a;
    io.req_we_i   = we;
    io.req_data_i = d;
    tick();
    io.req_v_i    = 1'b0;
    chk("ready_low_after_accept", 64'(io.req_ready_o), 64'd0);
  endtask

  task automatic consume();
    io.resp_yumi_i = 1'b1;
    tick();
    io.resp_yumi_i = 1'b0;
    chk("resp_v_after_yumi", 64'(io.resp_v_o), 64'd0);
    chk("ready_after_yumi", 64'(io.req_ready_o), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    checks          = 0;
    errors          = 0;
    reset_n_i       = 1'b0;
    io.req_v_i      = 1'b0;
    io.req_addr_i   = '0;
    io.req_we_i     = 1'b0;
    io.req_data_i   = '0;
    io.resp_yumi_i  = 1'b0;
    dev_ready_i     = '0;
    dev_resp_v_i    = '0;
    dev_resp_data_i = '0;

    // Reset values
    tick();
    tick();
    chk("rst_req_ready", 64'(io.req_ready_o), 64'd0);
    chk("rst_resp_v", 64'(io.resp_v_o), 64'd0);
    chk("rst_resp_err", 64'(io.resp_err_o), 64'd0);
    chk("rst_resp_data", io.resp_data_o, 64'd0);
    chk("rst_dev_v", 64'(dev_v_o), 64'd0);
    chk("rst_err_count", 64'(err_count_o), 64'd0);
    reset_n_i = 1'b1;
    chk("rel_ready_first", 64'(io.req_ready_o), 64'd0);
    tick();
    chk("rel_ready_second", 64'(io.req_ready_o), 64'd1);

    // Clint load, ready high, response two cycles after handshake
    dev_ready_i = 5'b11111;
    issue(40'h00_0030_bff8, 1'b0, 64'd0);
    chk("clint_dev_v", 64'(dev_v_o), 64'h08);
    chk("clint_dev_addr", 64'(dev_addr_o), 64'hbff8);
    chk("clint_dev_we", 64'(dev_we_o), 64'd0);
    chk("clint_resp_v_send", 64'(io.resp_v_o), 64'd0);
    tick();
    chk("clint_dev_v_wait", 64'(dev_v_o), 64'd0);
    tick();
    chk("clint_resp_v_wait", 64'(io.resp_v_o), 64'd0);
    dev_resp_v_i = 5'b01000;
    dev_resp_data_i[1*64 +: 64] = 64'hdead_dead_dead_dead;
    dev_resp_data_i[3*64 +: 64] = 64'h1234;
    tick();
    dev_resp_v_i = '0;
    chk("clint_resp_v", 64'(io.resp_v_o), 64'd1);
    chk("clint_resp_data", io.resp_data_o, 64'h1234);
    chk("clint_resp_err", 64'(io.resp_err_o), 64'd0);
    tick();
    chk("clint_resp_hold_v", 64'(io.resp_v_o), 64'd1);
    chk("clint_resp_hold_data", io.resp_data_o, 64'h1234);
    chk("clint_ready_in_resp", 64'(io.req_ready_o), 64'd0);
    consume();

    // Cfg store, target ready low 5 cycles (other devices ready)
    dev_ready_i = 5'b11011;
    issue(40'h00_0020_0010, 1'b1, 64'hcafe_f00d_0000_0010);
    for (int i = 0; i < 6; i++) begin
      chk("cfg_dev_v", 64'(dev_v_o), 64'h04);
      chk("cfg_dev_addr", 64'(dev_addr_o), 64'h00010);
      chk("cfg_dev_data", dev_data_o, 64'hcafe_f00d_0000_0010);
      chk("cfg_dev_we", 64'(dev_we_o), 64'd1);
      if (i == 5) dev_ready_i = 5'b00100;
      tick();
    end
    chk("cfg_single_handshake", 64'(dev_v_o), 64'd0);
    dev_resp_v_i = 5'b00100;
    dev_resp_data_i[2*64 +: 64] = 64'h5;
    tick();
    dev_resp_v_i = '0;
    chk("cfg_resp_v", 64'(io.resp_v_o), 64'd1);
    chk("cfg_resp_err", 64'(io.resp_err_o), 64'd0);
    chk("cfg_resp_data", io.resp_data_o, 64'h5);
    consume();

    // Unmapped dev_id 7
    dev_ready_i = 5'b11111;
    issue(40'h00_0070_0000, 1'b0, 64'd0);
    chk("unmap_dev_v", 64'(dev_v_o), 64'd0);
    chk("unmap_resp_v", 64'(io.resp_v_o), 64'd1);
    chk("unmap_resp_err", 64'(io.resp_err_o), 64'd1);
    chk("unmap_resp_data", io.resp_data_o, 64'd0);
    chk("unmap_err_count", 64'(err_count_o), 64'(ec1_lp));
    consume();

    // Host load with no response: timeout after 16 WAIT cycles
    issue(40'h00_0010_0000, 1'b0, 64'd0);
    chk("host_dev_v", 64'(dev_v_o), 64'h02);
    tick();
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) chk("host_no_resp_yet", 64'(io.resp_v_o), 64'd0);
    end
    chk("host_timeout_v", 64'(io.resp_v_o), 64'd1);
    chk("host_timeout_err", 64'(io.resp_err_o), 64'd1);
    chk("host_timeout_data", io.resp_data_o, 64'd0);
    chk("host_err_count", 64'(err_count_o), 64'(ec2_lp));
    tick();
    tick();
    dev_resp_v_i = 5'b00010;
    dev_resp_data_i[1*64 +: 64] = 64'hbad;
    chk("late_resp_ready", 64'(dev_resp_ready_o), 64'h1f);
    tick();
    dev_resp_v_i = '0;
    chk("late_keep_err", 64'(io.resp_err_o), 64'd1);
    chk("late_keep_data", io.resp_data_o, 64'd0);
    consume();

    // Next request after a timeout completes normally
    issue(40'h00_0030_0000, 1'b0, 64'd0);
    tick();
    dev_resp_v_i = 5'b01000;
    dev_resp_data_i[3*64 +: 64] = 64'habcd;
    tick();
    dev_resp_v_i = '0;
    chk("post_to_resp_data", io.resp_data_o, 64'habcd);
    chk("post_to_resp_err", 64'(io.resp_err_o), 64'd0);
    consume();

    // Response on the expiry cycle wins
    issue(40'h00_0040_0008, 1'b0, 64'd0);
    chk("cache_dev_v", 64'(dev_v_o), 64'h10);
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("tie_no_resp_yet", 64'(io.resp_v_o), 64'd0);
    dev_resp_v_i = 5'b10000;
    dev_resp_data_i[4*64 +: 64] = 64'h77;
    tick();
    dev_resp_v_i = '0;
    chk("tie_resp_v", 64'(io.resp_v_o), 64'd1);
    chk("tie_resp_err", 64'(io.resp_err_o), 64'd0);
    chk("tie_resp_data", io.resp_data_o, 64'h77);
    chk("tie_err_count", 64'(err_count_o), 64'(ec2_lp));
    consume();

    // Reset asserted in WAIT, then a boot load
    issue(40'h00_0010_0000, 1'b0, 64'd0);
    tick();
    tick();
    tick();
    reset_n_i = 1'b0;
    #2;
    chk("midrst_ready", 64'(io.req_ready_o), 64'd0);
    chk("midrst_resp_v", 64'(io.resp_v_o), 64'd0);
    chk("midrst_resp_data", io.resp_data_o, 64'd0);
    chk("midrst_dev_v", 64'(dev_v_o), 64'd0);
    chk("midrst_err_count", 64'(err_count_o), 64'd0);
    tick();
    reset_n_i = 1'b1;
    tick();
    issue(40'h00_0001_0000, 1'b0, 64'd0);
    chk("boot_dev_v", 64'(dev_v_o), 64'h01);
    chk("boot_dev_addr", 64'(dev_addr_o), 64'h10000);
    tick();
    chk("boot_resp_v_wait", 64'(io.resp_v_o), 64'd0);
    dev_resp_v_i = 5'b00001;
    dev_resp_data_i[0 +: 64] = 64'h42;
    tick();
    dev_resp_v_i = '0;
    chk("boot_resp_v", 64'(io.resp_v_o), 64'd1);
    chk("boot_resp_data", io.resp_data_o, 64'h42);
    chk("boot_resp_err", 64'(io.resp_err_o), 64'd0);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
